png_chunk_packer: RTL

PNG_CHUNK_PACKER -- requirements
Module: png_chunk_packer

---
 rtl/png_chunk_packer.sv | 372 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/png_chunk_packer.sv
// ---------------------------------------------------------------------------
// png_chunk_packer
//
// Wraps a zlib byte stream into a complete PNG file. The packer emits the
// signature, an IHDR chunk, one or more IDAT chunks and the IEND chunk. Each
// IDAT carries up to IDAT_SIZE bytes taken from an internal buffer.
//
// Parameters
//   IDAT_SIZE : maximum data bytes per IDAT chunk (power of 2, 16..4096)
//   CLR_TYPE  : IHDR colour-type byte (bit depth is always 8)
//
// Ports
//   clk            : clock, everything runs on its rising edge
//   rstn           : asynchronous reset, active high (1 = reset)
//   cfg_w_i/h_i    : image width/height, captured when start_i is seen in IDLE
//   start_i        : one-cycle frame start pulse
//   done_o         : one-cycle pulse once the last file byte has been taken
//   val_i/dat_i    : incoming zlib byte and its valid
//   lst_i          : last zlib byte of the frame (qualified by val_i)
//   rdy_o          : packer accepts an input byte (only while filling)
//   val_o/dat_o    : outgoing PNG byte and its valid
//   rdy_i          : downstream takes the outgoing byte
//
// The output byte lives in a register. The FSM works one byte ahead: it loads
// the next byte whenever the register is empty or is being emptied, and the
// byte counter steps with each load. A state whose successor is FILL waits
// until its final byte has left the register, so rdy_o never rises while a
// byte of the previous chunk is still pending.
// ---------------------------------------------------------------------------
module png_chunk_packer #(
    parameter int         IDAT_SIZE = 256,
    parameter logic [7:0] CLR_TYPE  = 8'd2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] cfg_w_i,
    input  logic [15:0] cfg_h_i,
    input  logic        start_i,
    output logic        done_o,
    input  logic        val_i,
    input  logic [7:0]  dat_i,
    input  logic        lst_i,
    output logic        rdy_o,
    output logic        val_o,
    output logic [7:0]  dat_o,
    input  logic        rdy_i
);

    localparam int AW = $clog2(IDAT_SIZE);
    // One extra bit so the fill count can hold IDAT_SIZE itself
    localparam int CW = AW + 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SIG      = 4'd1,
        ST_IHDR     = 4'd2,
        ST_FILL     = 4'd3,
        ST_IDAT_HDR = 4'd4,
        ST_IDAT_DAT = 4'd5,
        ST_IDAT_CRC = 4'd6,
        ST_IEND     = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] n_r;
    logic          last_r;
    logic [31:0]   crc_r;
    logic [15:0]   w_r;
    logic [15:0]   h_r;
    logic [7:0]    mem_r [IDAT_SIZE];
    logic [7:0]    dat_o_r;
    logic          val_o_r;
    logic          rdy_o_r;
    logic          done_o_r;

    logic          load_s;
    logic          acc_s;
    logic          full_s;
    logic          emit_s;
    logic          wrap_s;
    logic          drain_s;
    logic          crc_init_s;
    logic          crc_upd_s;
    logic [7:0]    byte_s;
    logic [31:0]   crc_next_s;
    logic [31:0]   crc_out_s;
    logic [31:0]   len_s;

    // CRC-32 (reflected 0xEDB88320), one byte per call
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int k = 0; k < 8; k++) begin
            if (c[0]) begin
                c = {1'b0, c[31:1]} ^ 32'hEDB88320;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

    // PNG signature byte by index
    function automatic logic [7:0] sig_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h89;
            3'd1:    b = 8'h50;
            3'd2:    b = 8'h4E;
            3'd3:    b = 8'h47;
            3'd4:    b = 8'h0D;
            3'd5:    b = 8'h0A;
            3'd6:    b = 8'h1A;
            3'd7:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // IEND chunk byte by index; its CRC is a fixed constant
    function automatic logic [7:0] iend_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd4:    b = 8'h49;
            4'd5:    b = 8'h45;
            4'd6:    b = 8'h4E;
            4'd7:    b = 8'h44;
            4'd8:    b = 8'hAE;
            4'd9:    b = 8'h42;
            4'd10:   b = 8'h60;
            4'd11:   b = 8'h82;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // IHDR chunk byte by index (length, type, 13 data bytes, CRC)
    function automatic logic [7:0] ihdr_byte(input logic [4:0] idx, input logic [15:0] w,
                                             input logic [15:0] h, input logic [31:0] crc);
        logic [7:0] b;
        case (idx)
            5'd3:    b = 8'h0D;
            5'd4:    b = 8'h49;
            5'd5:    b = 8'h48;
            5'd6:    b = 8'h44;
            5'd7:    b = 8'h52;
            5'd10:   b = w[15:8];
            5'd11:   b = w[7:0];
            5'd14:   b = h[15:8];
            5'd15:   b = h[7:0];
            5'd16:   b = 8'h08;
            5'd17:   b = CLR_TYPE;
            5'd21:   b = crc[31:24];
            5'd22:   b = crc[23:16];
            5'd23:   b = crc[15:8];
            5'd24:   b = crc[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign load_s     = !val_o_r || rdy_i;
    assign acc_s      = val_i && rdy_o_r;
    assign full_s     = (n_r == CW'(IDAT_SIZE - 1));
    assign crc_out_s  = ~crc_r;
    assign len_s      = 32'(n_r);
    assign crc_next_s = crc32_byte(crc_init_s ? 32'hFFFFFFFF : crc_r, byte_s);

    assign dat_o  = dat_o_r;
    assign val_o  = val_o_r;
    assign rdy_o  = rdy_o_r;
    assign done_o = done_o_r;

    // State register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_s = ST_SIG;
                else         state_s = ST_IDLE;
            end
            ST_SIG: begin
                if (emit_s && wrap_s) state_s = ST_IHDR;
                else                  state_s = ST_SIG;
            end
            ST_IHDR: begin
                if (drain_s) state_s = ST_FILL;
                else         state_s = ST_IHDR;
            end
            ST_FILL: begin
                if (acc_s && (full_s || lst_i)) state_s = ST_IDAT_HDR;
                else                            state_s = ST_FILL;
            end
            ST_IDAT_HDR: begin
                if (emit_s && wrap_s) state_s = ST_IDAT_DAT;
                else                  state_s = ST_IDAT_HDR;
            end
            ST_IDAT_DAT: begin
                if (emit_s && wrap_s) state_s = ST_IDAT_CRC;
                else                  state_s = ST_IDAT_DAT;
            end
            ST_IDAT_CRC: begin
                if (drain_s) state_s = last_r ? ST_IEND : ST_FILL;
                else         state_s = ST_IDAT_CRC;
            end
            ST_IEND: begin
                if (emit_s && wrap_s) state_s = ST_DONE;
                else                  state_s = ST_IEND;
            end
            ST_DONE: begin
                if (drain_s) state_s = ST_IDLE;
                else         state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: which byte to load next, and CRC / counter controls
    always_comb begin
        emit_s     = 1'b0;
        wrap_s     = 1'b0;
        drain_s    = 1'b0;
        crc_init_s = 1'b0;
        crc_upd_s  = 1'b0;
        byte_s     = 8'h00;
        case (state_r)
            ST_IDLE: begin
                // The first signature byte is loaded on the start edge itself
                emit_s = start_i;
                byte_s = 8'h89;
            end
            ST_SIG: begin
                emit_s = load_s;
                byte_s = sig_byte(cnt_r[2:0]);
                wrap_s = (cnt_r == CW'(7));
            end
            ST_IHDR: begin
                if (cnt_r == CW'(25)) begin
                    drain_s = load_s;
                end else begin
                    emit_s     = load_s;
                    byte_s     = ihdr_byte(cnt_r[4:0], w_r, h_r, crc_out_s);
                    crc_init_s = (cnt_r == CW'(4));
                    crc_upd_s  = (cnt_r > CW'(4)) && (cnt_r < CW'(21));
                end
            end
            ST_IDAT_HDR: begin
                emit_s = load_s;
                case (cnt_r[2:0])
                    3'd0:    byte_s = len_s[31:24];
                    3'd1:    byte_s = len_s[23:16];
                    3'd2:    byte_s = len_s[15:8];
                    3'd3:    byte_s = len_s[7:0];
                    3'd4:    byte_s = 8'h49;
                    3'd5:    byte_s = 8'h44;
                    3'd6:    byte_s = 8'h41;
                    3'd7:    byte_s = 8'h54;
                    default: byte_s = 8'h00;
                endcase
                crc_init_s = (cnt_r == CW'(4));
                crc_upd_s  = (cnt_r > CW'(4));
                wrap_s     = (cnt_r == CW'(7));
            end
            ST_IDAT_DAT: begin
                emit_s    = load_s;
                byte_s    = mem_r[cnt_r[AW-1:0]];
                crc_upd_s = 1'b1;
                // n is at least 1 here, so n-1 never wraps
                wrap_s    = (cnt_r == (n_r - CW'(1)));
            end
            ST_IDAT_CRC: begin
                if (cnt_r == CW'(4)) begin
                    drain_s = load_s;
                end else begin
                    emit_s = load_s;
                    case (cnt_r[1:0])
                        2'd0:    byte_s = crc_out_s[31:24];
                        2'd1:    byte_s = crc_out_s[23:16];
                        2'd2:    byte_s = crc_out_s[15:8];
                        2'd3:    byte_s = crc_out_s[7:0];
                        default: byte_s = 8'h00;
                    endcase
                end
            end
            ST_IEND: begin
                emit_s = load_s;
                byte_s = iend_byte(cnt_r[3:0]);
                wrap_s = (cnt_r == CW'(11));
            end
            ST_DONE: begin
                drain_s = load_s;
            end
            ST_FILL: begin
                emit_s = 1'b0;
            end
            default: begin
                emit_s = 1'b0;
            end
        endcase
    end

    // Datapath registers: output byte, counters, CRC, config and flags
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            dat_o_r  <= 8'h00;
            val_o_r  <= 1'b0;
            rdy_o_r  <= 1'b0;
            done_o_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            n_r      <= {CW{1'b0}};
            last_r   <= 1'b0;
            crc_r    <= 32'h00000000;
            w_r      <= 16'h0000;
            h_r      <= 16'h0000;
        end else begin
            if (emit_s) begin
                val_o_r <= 1'b1;
                dat_o_r <= byte_s;
            end else if (rdy_i) begin
                val_o_r <= 1'b0;
            end

            rdy_o_r  <= (state_s == ST_FILL);
            done_o_r <= (state_r == ST_DONE) && drain_s;

            if (emit_s) begin
                if (wrap_s) cnt_r <= {CW{1'b0}};
                else        cnt_r <= cnt_r + CW'(1);
            end else if (drain_s) begin
                cnt_r <= {CW{1'b0}};
            end

            if (acc_s) begin
                n_r <= n_r + CW'(1);
            end else if ((state_r == ST_IDAT_CRC) && drain_s) begin
                n_r <= {CW{1'b0}};
            end

            if ((state_r == ST_IDLE) && start_i) begin
                last_r <= 1'b0;
                w_r    <= cfg_w_i;
                h_r    <= cfg_h_i;
            end else if (acc_s && (full_s || lst_i)) begin
                last_r <= lst_i;
            end

            if (emit_s && (crc_init_s || crc_upd_s)) begin
                crc_r <= crc_next_s;
            end
        end
    end

    // IDAT payload buffer, written at the current fill count
    always_ff @(posedge clk) begin
        if (acc_s) begin
            mem_r[n_r[AW-1:0]] <= dat_i;
        end
    end

endmodule
